uart_msg_deframer: RTL



---
 rtl/uart_msg_deframer_if.sv | 27 ++
 rtl/uart_msg_deframer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_deframer_if.sv
// Byte-stream input and host pop/status signals of the UART message deframer.
// The deframer uses the slave modport; host-side logic uses the master modport.
interface uart_msg_deframer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        RD_REQ;
    logic        RD_REQ_LEN;
    logic [15:0] FIFO_Q;
    logic [7:0]  MSG_LEN;
    logic        PARITY_OUT;
    logic        GOT_FULL_MESSAGE;
    logic [7:0]  CRC_ERR_CNT;
    logic [7:0]  DROP_CNT;

    modport slave (
        input  rx_data, rx_valid, RD_REQ, RD_REQ_LEN,
        output rx_ready, FIFO_Q, MSG_LEN, PARITY_OUT, GOT_FULL_MESSAGE,
               CRC_ERR_CNT, DROP_CNT
    );

    modport master (
        output rx_data, rx_valid, RD_REQ, RD_REQ_LEN,
        input  rx_ready, FIFO_Q, MSG_LEN, PARITY_OUT, GOT_FULL_MESSAGE,
               CRC_ERR_CNT, DROP_CNT
    );
endinterface

// File: rtl/uart_msg_deframer.sv
// Parses SYNC/LEN/FLAGS/words/CHK frames from a UART byte stream, speculatively writes
// words into a FIFO and commits them with a length descriptor only when the checksum matches.
module uart_msg_deframer #(
    parameter int         DATA_AW   = 9,
    parameter int         MSG_AW    = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hAA,
    parameter int         TIMEOUT   = 20000
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_msg_deframer_if.slave   bus
);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int WORDS  = 1 << DATA_AW;
    localparam int DESCS  = 1 << MSG_AW;
    localparam logic [DATA_AW:0] WORD_DEPTH = {1'b1, {DATA_AW{1'b0}}};
    localparam logic [MSG_AW:0]  DESC_DEPTH = {1'b1, {MSG_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_FLAGS, S_DATA_HI, S_DATA_LO, S_CHK, S_DISCARD
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       len_reg, len_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic [7:0]       xor_reg, xor_next;
    logic             parity_reg, parity_next;
    logic [7:0]       hi_reg, hi_next;
    logic [9:0]       remain_reg, remain_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [DATA_AW:0] spec_wr_reg, spec_wr_next;
    logic [DATA_AW:0] commit_wr_reg, commit_wr_next;
    logic [DATA_AW:0] rd_reg, rd_next;
    logic [MSG_AW:0]  desc_wr_reg, desc_wr_next;
    logic [MSG_AW:0]  desc_rd_reg, desc_rd_next;
    logic [7:0]       crc_cnt_reg, crc_cnt_next;
    logic [7:0]       drop_cnt_reg, drop_cnt_next;
    logic             rx_ready_reg;
    logic [15:0]      fifo_q_reg;
    logic [8:0]       desc_q_reg;

    logic [15:0]      word_mem [0:WORDS-1];
    logic [8:0]       desc_mem [0:DESCS-1];

    logic             accept, mem_we, desc_push, crc_inc, drop_inc;
    logic             word_pop, desc_pop, desc_full;
    logic [DATA_AW:0] used_words, free_words;

    assign accept     = bus.rx_valid && rx_ready_reg;
    // Occupancy counts speculative words too, so an in-flight frame can never overrun unread data.
    assign used_words = spec_wr_reg - rd_reg;
    assign free_words = WORD_DEPTH - used_words;
    assign desc_full  = (desc_wr_reg - desc_rd_reg) == DESC_DEPTH;

    assign word_pop     = bus.RD_REQ && (rd_reg != commit_wr_reg);
    assign desc_pop     = bus.RD_REQ_LEN && (desc_rd_reg != desc_wr_reg);
    assign rd_next      = rd_reg + {{DATA_AW{1'b0}}, word_pop};
    assign desc_rd_next = desc_rd_reg + {{MSG_AW{1'b0}}, desc_pop};
    assign desc_wr_next = desc_wr_reg + {{MSG_AW{1'b0}}, desc_push};

    assign crc_cnt_next  = (crc_inc && crc_cnt_reg != 8'hFF) ? crc_cnt_reg + 8'd1 : crc_cnt_reg;
    assign drop_cnt_next = (drop_inc && drop_cnt_reg != 8'hFF) ? drop_cnt_reg + 8'd1 : drop_cnt_reg;

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        xor_next       = xor_reg;
        parity_next    = parity_reg;
        hi_next        = hi_reg;
        remain_next    = remain_reg;
        timer_next     = timer_reg;
        spec_wr_next   = spec_wr_reg;
        commit_wr_next = commit_wr_reg;
        mem_we         = 1'b0;
        desc_push      = 1'b0;
        crc_inc        = 1'b0;
        drop_inc       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept && bus.rx_data == SYNC_BYTE) state_next = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (bus.rx_data == 8'd0) begin
                        state_next = S_IDLE;
                        crc_inc    = 1'b1;
                    end else if (desc_full || 32'(free_words) < 32'(bus.rx_data)) begin
                        state_next  = S_DISCARD;
                        remain_next = {1'b0, bus.rx_data, 1'b0} + 10'd2;
                        drop_inc    = 1'b1;
                    end else begin
                        len_next   = bus.rx_data;
                        xor_next   = bus.rx_data;
                        state_next = S_FLAGS;
                    end
                end
            end
            S_FLAGS: begin
                if (accept) begin
                    parity_next = bus.rx_data[0];
                    xor_next    = xor_reg ^ bus.rx_data;
                    cnt_next    = 8'd0;
                    state_next  = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_next    = bus.rx_data;
                    xor_next   = xor_reg ^ bus.rx_data;
                    state_next = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    mem_we       = 1'b1;
                    spec_wr_next = spec_wr_reg + {{DATA_AW{1'b0}}, 1'b1};
                    xor_next     = xor_reg ^ bus.rx_data;
                    cnt_next     = cnt_reg + 8'd1;
                    state_next   = (cnt_reg + 8'd1 == len_reg) ? S_CHK : S_DATA_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_next = S_IDLE;
                    if (bus.rx_data == xor_reg) begin
                        commit_wr_next = spec_wr_reg;
                        desc_push      = 1'b1;
                    end else begin
                        spec_wr_next = commit_wr_reg;
                        crc_inc      = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                if (accept) begin
                    remain_next = remain_reg - 10'd1;
                    if (remain_reg == 10'd1) state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Inter-byte watchdog: an abort only happens in a cycle with no accepted byte.
        if (state_reg == S_IDLE || accept) begin
            timer_next = '0;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            state_next   = S_IDLE;
            spec_wr_next = commit_wr_reg;
            crc_inc      = 1'b1;
            timer_next   = '0;
        end else begin
            timer_next = timer_reg + TW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            cnt_reg       <= '0;
            xor_reg       <= '0;
            parity_reg    <= 1'b0;
            hi_reg        <= '0;
            remain_reg    <= '0;
            timer_reg     <= '0;
            spec_wr_reg   <= '0;
            commit_wr_reg <= '0;
            rd_reg        <= '0;
            desc_wr_reg   <= '0;
            desc_rd_reg   <= '0;
            crc_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
            rx_ready_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            xor_reg       <= xor_next;
            parity_reg    <= parity_next;
            hi_reg        <= hi_next;
            remain_reg    <= remain_next;
            timer_reg     <= timer_next;
            spec_wr_reg   <= spec_wr_next;
            commit_wr_reg <= commit_wr_next;
            rd_reg        <= rd_next;
            desc_wr_reg   <= desc_wr_next;
            desc_rd_reg   <= desc_rd_next;
            crc_cnt_reg   <= crc_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
            rx_ready_reg  <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) word_mem[spec_wr_reg[DATA_AW-1:0]] <= {hi_reg, bus.rx_data};
    end

    // Show-ahead head register; addresses below spec_wr were written in earlier cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_q_reg <= '0;
        end else if (rd_next != commit_wr_next) begin
            fifo_q_reg <= word_mem[rd_next[DATA_AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (desc_push) desc_mem[desc_wr_reg[MSG_AW-1:0]] <= {parity_reg, len_reg};
    end

    // A descriptor pushed into an empty queue is forwarded because its entry is written this edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            desc_q_reg <= '0;
        end else if (desc_rd_next != desc_wr_next) begin
            if (desc_push && desc_rd_next == desc_wr_reg) desc_q_reg <= {parity_reg, len_reg};
            else                                          desc_q_reg <= desc_mem[desc_rd_next[MSG_AW-1:0]];
        end
    end

    assign bus.rx_ready         = rx_ready_reg;
    assign bus.FIFO_Q           = fifo_q_reg;
    assign bus.MSG_LEN          = desc_q_reg[7:0];
    assign bus.PARITY_OUT       = desc_q_reg[8];
    assign bus.GOT_FULL_MESSAGE = desc_wr_reg != desc_rd_reg;
    assign bus.CRC_ERR_CNT      = crc_cnt_reg;
    assign bus.DROP_CNT         = drop_cnt_reg;
endmodule
